// File: rtl/prio_enc_serializer.sv
// Serialises every set bit of an N-bit request vector into a stream of binary
// indices, one per out_valid/out_ready beat, lowest-first or highest-first.
module prio_enc_serializer #(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_vec,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [$clog2(N)-1:0] out_idx,
  output logic                 out_last,
  output logic                 zero_in
);
  localparam int W = $clog2(N);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t       r_state, w_state_nxt;
  logic [N-1:0] r_pending, w_pending_nxt, w_sel;
  logic [W-1:0] w_idx;
  logic         w_last, w_accept, r_zero;

  // Later loop iterations override earlier ones, so the scan direction picks
  // which end of the vector wins.
  always_comb begin
    w_idx = '0;
    w_sel = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < N; i++) begin
        if (r_pending[i]) begin
          w_idx    = W'(i);
          w_sel    = '0;
          w_sel[i] = 1'b1;
        end
      end
    end else begin
      for (int i = N-1; i >= 0; i--) begin
        if (r_pending[i]) begin
          w_idx    = W'(i);
          w_sel    = '0;
          w_sel[i] = 1'b1;
        end
      end
    end
  end

  assign w_last   = (r_pending != '0) && ((r_pending & (r_pending - N'(1))) == '0);
  assign w_accept = in_valid && (r_state == IDLE);

  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    case (r_state)
      IDLE: begin
        if (w_accept && (in_vec != '0)) begin
          w_pending_nxt = in_vec;
          w_state_nxt   = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          w_pending_nxt = r_pending & ~w_sel;
          if (w_last) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_zero    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_zero    <= w_accept && (in_vec == '0);
    end
  end

  // All outputs derive from registers only; pending is zero outside EMIT.
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == EMIT);
  assign out_idx   = w_idx;
  assign out_last  = w_last;
  assign zero_in   = r_zero;
endmodule
